// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch sequencer: FSM states and branch-type selects.
// Optional build macro: FETCH_PERF_CNT_EN (adds performance counters to fetch_sequencer).
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STALL = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [1:0] BR_COND   = 2'b00;
  localparam logic [1:0] BR_UNCOND = 2'b01;
  localparam logic [1:0] BR_LINK   = 2'b10;
  localparam logic [1:0] BR_REG    = 2'b11;

  // Branch-type select from the decoder flags; several set -> reg > link > uncond > cond.
  function automatic logic [1:0] br_sel(input logic is_reg, input logic is_link,
                                        input logic is_uncond);
    if (is_reg)         return BR_REG;
    else if (is_link)   return BR_LINK;
    else if (is_uncond) return BR_UNCOND;
    else                return BR_COND;
  endfunction

endpackage

// File: rtl/fetch_flush_timer.sv
// Loadable down-counter that sets the length of the post-branch FLUSH phase.
// done is high while the current FLUSH cycle is the last one (count <= 1).
module fetch_flush_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  // Load on a taken branch, otherwise count down while flushing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       count <= '0;
    else if (load)                   count <= value;
    else if (dec && count != '0)     count <= count - W'(1);
  end

  assign done = (count <= W'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: advance / hold / redirect / freeze the PC and
// steer the IF/ID register. Branch and enable outputs are combinational from
// state and ID inputs so the datapath can use them in the same cycle.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_taken / perf_stall counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_is_cond,
  input  logic             id_is_uncond,
  input  logic             id_is_link,
  input  logic             id_is_reg,
  input  logic             cond_flag,
  input  logic             load_use_stall,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             br_taken,
  output logic [1:0]       branch_type,
  output logic             reg_branch,
  output logic             link_we,
  output logic             halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [CNT_W-1:0] perf_taken,
  output logic [CNT_W-1:0] perf_stall,
`endif
  output logic [2:0]       state_o
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t state, nxt;
  logic   taken, tmr_load, tmr_dec, tmr_done;

  assign taken = id_is_uncond | id_is_link | id_is_reg | (id_is_cond & cond_flag);

  fetch_flush_timer #(.W(2)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .value (FLUSH_LOAD),
    .done  (tmr_done)
  );

  // Next-state and same-cycle datapath controls; everything forced low while reset is held.
  always_comb begin
    nxt         = state;
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    if_id_flush = 1'b0;
    br_taken    = 1'b0;
    branch_type = BR_COND;
    reg_branch  = 1'b0;
    link_we     = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    case (state)
      ST_BOOT: begin
        if_id_flush = 1'b1;
        nxt         = ST_RUN;
      end
      ST_RUN: begin
        pc_we    = 1'b1;
        if_id_we = 1'b1;
        if (id_valid) begin
          if (halt_i) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            nxt      = ST_HALT;
          end else if (load_use_stall) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            nxt      = ST_STALL;
          end else if (taken) begin
            br_taken    = 1'b1;
            if_id_flush = 1'b1;
            branch_type = br_sel(id_is_reg, id_is_link, id_is_uncond);
            reg_branch  = id_is_reg;
            link_we     = id_is_link;
            tmr_load    = 1'b1;
            nxt         = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
          end
        end
      end
      ST_STALL: begin
        if (!load_use_stall) begin
          pc_we    = 1'b1;
          if_id_we = 1'b1;
          nxt      = ST_RUN;
        end
      end
      ST_FLUSH: begin
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        if_id_flush = 1'b1;
        tmr_dec     = 1'b1;
        if (tmr_done) nxt = ST_RUN;
      end
      ST_HALT: begin
        if (resume_i) nxt = ST_RUN;
      end
      default: nxt = ST_BOOT;
    endcase
    if (reset) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      if_id_flush = 1'b0;
      br_taken    = 1'b0;
      branch_type = BR_COND;
      reg_branch  = 1'b0;
      link_we     = 1'b0;
      tmr_load    = 1'b0;
      tmr_dec     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_BOOT;
    else       state <= nxt;
  end

  assign halted  = (state == ST_HALT);
  assign state_o = state;

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters: taken branches, and cycles with the PC held outside BOOT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_taken <= '0;
      perf_stall <= '0;
    end else begin
      if (br_taken && perf_taken != '1)
        perf_taken <= perf_taken + CNT_W'(1);
      if (!pc_we && state != ST_BOOT && perf_stall != '1)
        perf_stall <= perf_stall + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (FLUSH_CYCLES=2). Inputs change 1ns after
// the rising edge; outputs are checked mid-cycle against hand-computed vectors.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_is_cond, id_is_uncond, id_is_link, id_is_reg;
  logic       cond_flag, load_use_stall, halt_i, resume_i;
  logic       pc_we, if_id_we, if_id_flush, br_taken, reg_branch, link_we, halted;
  logic [1:0] branch_type;
  logic [2:0] state_o;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_taken, perf_stall;
`endif

  int n_run  = 0;
  int n_fail = 0;

  fetch_sequencer #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_is_cond     (id_is_cond),
    .id_is_uncond   (id_is_uncond),
    .id_is_link     (id_is_link),
    .id_is_reg      (id_is_reg),
    .cond_flag      (cond_flag),
    .load_use_stall (load_use_stall),
    .halt_i         (halt_i),
    .resume_i       (resume_i),
    .pc_we          (pc_we),
    .if_id_we       (if_id_we),
    .if_id_flush    (if_id_flush),
    .br_taken       (br_taken),
    .branch_type    (branch_type),
    .reg_branch     (reg_branch),
    .link_we        (link_we),
    .halted         (halted),
`ifdef FETCH_PERF_CNT_EN
    .perf_taken     (perf_taken),
    .perf_stall     (perf_stall),
`endif
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  // {pc_we, if_id_we, if_id_flush, br_taken, branch_type, reg_branch, link_we, halted, state}
  function automatic logic [11:0] ev(input logic pw, input logic iw, input logic fl,
                                     input logic bt, input logic [1:0] ty, input logic rb,
                                     input logic lw, input logic h, input logic [2:0] st);
    return {pw, iw, fl, bt, ty, rb, lw, h, st};
  endfunction

  task automatic chk(input string tag, input logic [11:0] exp_v);
    logic [11:0] obs;
    obs = {pc_we, if_id_we, if_id_flush, br_taken, branch_type, reg_branch, link_we,
           halted, state_o};
    n_run++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_is_cond = 0; id_is_uncond = 0; id_is_link = 0; id_is_reg = 0;
    cond_flag = 0; load_use_stall = 0; halt_i = 0; resume_i = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    #3 chk("reset_state", ev(0,0,0,0,2'b00,0,0,0,3'd0));

    // Release reset: one BOOT cycle, then RUN.
    tick(); reset = 1'b0;
    #3 chk("boot", ev(0,0,1,0,2'b00,0,0,0,3'd0));
    tick();
    #3 chk("run_idle", ev(1,1,0,0,2'b00,0,0,0,3'd1));

    // Taken conditional, then one FLUSH cycle that ignores the still-set branch inputs.
    tick(); id_valid = 1; id_is_cond = 1; cond_flag = 1;
    #3 chk("cond_taken", ev(1,1,1,1,2'b00,0,0,0,3'd1));
    tick();
    #3 chk("flush_after_cond", ev(1,1,1,0,2'b00,0,0,0,3'd3));

    // Not-taken conditional: plain RUN, no bubble.
    tick(); cond_flag = 0;
    #3 chk("cond_not_taken", ev(1,1,0,0,2'b00,0,0,0,3'd1));
    tick();
    #3 chk("cond_not_taken_stay", ev(1,1,0,0,2'b00,0,0,0,3'd1));

    // Register branch blocked by a load-use stall, then taken from RUN.
    tick(); idle(); id_valid = 1; id_is_reg = 1; load_use_stall = 1;
    #3 chk("reg_stalled", ev(0,0,0,0,2'b00,0,0,0,3'd1));
    tick(); load_use_stall = 0;
    #3 chk("stall_release", ev(1,1,0,0,2'b00,0,0,0,3'd2));
    tick();
    #3 chk("reg_taken", ev(1,1,1,1,2'b11,1,0,0,3'd1));
    tick(); idle();
    #3 chk("flush_after_reg", ev(1,1,1,0,2'b00,0,0,0,3'd3));

    // Branch-and-link.
    tick(); id_valid = 1; id_is_link = 1;
    #3 chk("link_taken", ev(1,1,1,1,2'b10,0,1,0,3'd1));
    tick(); idle();
    #3 chk("flush_after_link", ev(1,1,1,0,2'b00,0,0,0,3'd3));

    // Uncond + not-taken cond together: uncond wins the type select.
    tick(); id_valid = 1; id_is_uncond = 1; id_is_cond = 1;
    #3 chk("uncond_prio", ev(1,1,1,1,2'b01,0,0,0,3'd1));
    tick(); idle();
    #3 chk("flush_after_uncond", ev(1,1,1,0,2'b00,0,0,0,3'd3));

    // id_valid low: branch and halt inputs ignored.
    tick(); id_is_uncond = 1; halt_i = 1; load_use_stall = 1;
    #3 chk("invalid_ignored", ev(1,1,0,0,2'b00,0,0,0,3'd1));

    // Halt outranks stall and branch; hold until resume.
    tick(); id_valid = 1;
    #3 chk("halt_enter", ev(0,0,0,0,2'b00,0,0,0,3'd1));
    tick(); idle();
    #3 chk("halted", ev(0,0,0,0,2'b00,0,0,1,3'd4));
    tick(); resume_i = 1;
    #3 chk("halted_resume", ev(0,0,0,0,2'b00,0,0,1,3'd4));
    tick(); resume_i = 0;
    #3 chk("resumed_run", ev(1,1,0,0,2'b00,0,0,0,3'd1));

    // Stall held for two cycles.
    tick(); id_valid = 1; load_use_stall = 1;
    #3 chk("stall_enter", ev(0,0,0,0,2'b00,0,0,0,3'd1));
    tick();
    #3 chk("stall_hold", ev(0,0,0,0,2'b00,0,0,0,3'd2));
    tick(); load_use_stall = 0;
    #3 chk("stall_exit", ev(1,1,0,0,2'b00,0,0,0,3'd2));

    // Reset during FLUSH: outputs drop at once, then a clean BOOT.
    tick(); idle(); id_valid = 1; id_is_cond = 1; cond_flag = 1;
    #3 chk("cond_taken2", ev(1,1,1,1,2'b00,0,0,0,3'd1));
    tick(); idle();
    #3 chk("in_flush", ev(1,1,1,0,2'b00,0,0,0,3'd3));
    reset = 1'b1;
    #1 chk("reset_mid_flush", ev(0,0,0,0,2'b00,0,0,0,3'd0));
    tick(); reset = 1'b0;
    #3 chk("boot_after_flush_reset", ev(0,0,1,0,2'b00,0,0,0,3'd0));
    tick();
    #3 chk("run_no_leftover", ev(1,1,0,0,2'b00,0,0,0,3'd1));

    // Reset asserted during a taken-branch cycle.
    tick(); id_valid = 1; id_is_uncond = 1;
    #3 chk("uncond_taken", ev(1,1,1,1,2'b01,0,0,0,3'd1));
    reset = 1'b1;
    #1 chk("reset_mid_branch", ev(0,0,0,0,2'b00,0,0,0,3'd0));
    tick(); reset = 1'b0; idle();
    #3 chk("boot_after_branch_reset", ev(0,0,1,0,2'b00,0,0,0,3'd0));
    tick();
    #3 chk("run_after_branch_reset", ev(1,1,0,0,2'b00,0,0,0,3'd1));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
